csa_pipe_adder: RTL and testbench
=================================

// Module: csa_pipe_adder
// PURPOSE
//  Parametrised, pipelined conditional-sum adder/subtractor with valid/ready handshake.
//  Successor to the fixed 16-bit combinational conditional-sum adder.
//  Builds a WIDTH-bit datapath from the same per-level {sum0,sum1} merge tree, with register
//  slices between merge levels. Sits in arithmetic datapaths that need a throughput of one
//  operation per clock and back-pressure.
// PARAMETERS
//  WIDTH       32  operand width; power of two, 2..64
//  PIPE_EVERY  1   insert a register slice after every PIPE_EVERY merge levels; 1..LOG2W
//  LOG2W       derived = $clog2(WIDTH); not overridable
//  NSTAGE      derived = ceil(LOG2W/PIPE_EVERY); pipeline depth in cycles
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block accepts a beat this cycle
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  in_cin     in   1        carry-in; ignored when in_sub=1
//  in_sub     in   1        1 = A-B (B inverted, cin forced 1)
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_sum    out  WIDTH    result bits [WIDTH-1:0]
//  out_cout   out  1        carry-out (add); NOT borrow for sub, i.e. 1 when A>=B unsigned
//  out_ovf    out  1        signed overflow: operand signs equal (after B inversion) and sum sign differs
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits 0, out_valid 0, out_sum/out_cout/out_ovf 0.
//    In-flight beats are dropped. No output X after reset.
//  - Level 0: per-bit pair {a&b, a^b} (cin=0) and {a|b, ~(a^b)} (cin=1).
//  - Level k merges 2^k-bit blocks: the upper block's sum0/sum1 is selected by the lower block's
//    carry-out, for both the cin=0 and cin=1 hypotheses. Widths grow by 1 carry bit per block.
//  - Final select by the effective cin, after level LOG2W-1.
//    cin, sub and operand MSBs travel in sideband registers alongside each slice.
//  - Register slice placement:
//    - after merge levels PIPE_EVERY-1, 2*PIPE_EVERY-1, ...
//    - the last slice always drives the outputs, so latency = NSTAGE cycles from accept to out_valid.
//  - Handshake: global advance adv = !out_valid | out_ready; in_ready = adv.
//    - Beat accepted when in_valid & in_ready.
//    - All slices shift when adv=1. A slice loads valid=0 when its upstream holds no beat (bubble).
//    - When adv=0 every slice holds. Bubbles are not squeezed out.
//  - out_* stable while out_valid & !out_ready. Throughput 1 beat/clk with out_ready held high.
//  - Ordering strictly FIFO. No beat is lost or duplicated under any in_valid/out_ready pattern.
//  - Simultaneous accept and output on the same cycle with a full pipeline: allowed, no stall.
//  - Arithmetic is modulo 2^WIDTH. {out_cout,out_sum} == A + (sub?~B:B) + (sub?1:cin).
// STRUCTURE
//  - csa_pkg: csa_clog2 function and the localparam rule for NSTAGE; shared with future CSA blocks.
//  - Sub-module csa_merge_level #(BLK,NBLK):
//    - combinational merge of NBLK block pairs of width BLK, {sum0,sum1} in/out
//    - instantiated LOG2W times via generate.
//  - Top: generate loop of merge levels, conditional register slices, handshake control.
// TESTING
//  1. Reset mid-stream: assert rst_n low with 3 beats in flight -> out_valid=0 next edge, no stale beat after release.
//  2. WIDTH=16, PIPE_EVERY=1, add 0x00CD+0x00FC cin=1 -> out_sum=0x01CA, cout=0, ovf=0, after exactly 4 cycles.
//  3. WIDTH=32, PIPE_EVERY=1, add 0xFFFFFFFF+0x00000000 cin=1 -> sum=0x00000000, cout=1.
//     Add 0x7FFFFFFF+1 cin=0 -> sum=0x80000000, cout=0, ovf=1.
//  4. WIDTH=32, PIPE_EVERY=1, sub 5-7 -> sum=0xFFFFFFFE, cout=0. Sub 7-5 -> sum=2, cout=1.
//     Sub 0x80000000-1 -> ovf=1.
//  5. Back-pressure: 100 random beats, random in_valid and out_ready (50%) -> order preserved.
//     Every result matches the golden model. out_* stable while stalled.
//  6. Sweep WIDTH in {2,8,64} x PIPE_EVERY in {1,2,LOG2W}, 1000 random beats each, out_ready=1 ->
//     latency == NSTAGE, 1 result/clk, all bit-exact.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the conditional-sum adder family: width/depth helpers
// and the sideband record that rides alongside each register slice.
package csa_pkg;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int csa_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pipeline depth: one slice per PIPE_EVERY merge levels, rounded up.
  function automatic int csa_nstage(input int log2w, input int pipe_every);
    return (log2w + pipe_every - 1) / pipe_every;
  endfunction

  // Per-beat sideband: effective carry-in and operand sign bits (B after inversion).
  typedef struct packed {
    logic cin;
    logic a_msb;
    logic b_msb;
  } csa_side_t;

endpackage

// File: rtl/csa_merge_level.sv
// One conditional-sum merge level: pairs of BLK-bit blocks, each carrying
// {carry,sum} for both carry-in hypotheses, fuse into 2*BLK-bit blocks.
module csa_merge_level #(
  parameter int BLK  = 1,
  parameter int NBLK = 1
) (
  input  logic [2*NBLK*(BLK+1)-1:0] in0,
  input  logic [2*NBLK*(BLK+1)-1:0] in1,
  output logic [NBLK*(2*BLK+1)-1:0] out0,
  output logic [NBLK*(2*BLK+1)-1:0] out1
);

  localparam int BW = BLK + 1;
  localparam int OW = 2 * BLK + 1;

  for (genvar i = 0; i < NBLK; i++) begin : g_pair
    logic [BLK:0] lo0, lo1, hi0, hi1;

    assign lo0 = in0[2*i*BW +: BW];
    assign lo1 = in1[2*i*BW +: BW];
    assign hi0 = in0[(2*i+1)*BW +: BW];
    assign hi1 = in1[(2*i+1)*BW +: BW];

    // The lower block's carry-out picks which upper-block hypothesis is real.
    assign out0[i*OW +: OW] = {(lo0[BLK] ? hi1 : hi0), lo0[BLK-1:0]};
    assign out1[i*OW +: OW] = {(lo1[BLK] ? hi1 : hi0), lo1[BLK-1:0]};
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined conditional-sum adder/subtractor with a single global advance
// signal; register slices sit between merge levels and the last one drives the outputs.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LOG2W = csa_clog2(WIDTH);
  localparam int LAST  = LOG2W - 1;

  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  csa_side_t        in_side;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = in_sub ? ~in_b : in_b;
  assign cin_eff  = in_sub | in_cin;
  assign in_side  = {cin_eff, in_a[WIDTH-1], b_eff[WIDTH-1]};

  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    localparam int  BLK   = 1 << k;
    localparam int  NBLK  = WIDTH >> (k + 1);
    localparam int  IW    = 2 * NBLK * (BLK + 1);
    localparam int  OW    = NBLK * (2 * BLK + 1);
    localparam bit  SLICE = (((k + 1) % PIPE_EVERY) == 0) && (k != LAST);

    logic [IW-1:0] d0, d1;
    logic          u_vld;
    csa_side_t     u_side;
    logic [OW-1:0] m0, m1;
    logic [OW-1:0] q0, q1;
    logic          q_vld;
    csa_side_t     q_side;

    if (k == 0) begin : g_src
      // Per-bit {carry,sum} for carry-in 0 and carry-in 1.
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign d0[2*i +: 2] = {in_a[i] & b_eff[i], in_a[i] ^ b_eff[i]};
        assign d1[2*i +: 2] = {in_a[i] | b_eff[i], ~(in_a[i] ^ b_eff[i])};
      end
      assign u_vld  = in_valid;
      assign u_side = in_side;
    end else begin : g_chain
      assign d0     = g_lvl[k-1].q0;
      assign d1     = g_lvl[k-1].q1;
      assign u_vld  = g_lvl[k-1].q_vld;
      assign u_side = g_lvl[k-1].q_side;
    end

    csa_merge_level #(
      .BLK  (BLK),
      .NBLK (NBLK)
    ) u_merge (
      .in0  (d0),
      .in1  (d1),
      .out0 (m0),
      .out1 (m1)
    );

    if (SLICE) begin : g_slice
      // ---- register slice after merge level k ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_vld <= 1'b0;
        end else if (adv) begin
          q_vld <= u_vld;
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          q0     <= m0;
          q1     <= m1;
          q_side <= u_side;
        end
      end
    end else begin : g_thru
      assign q0     = m0;
      assign q1     = m1;
      assign q_vld  = u_vld;
      assign q_side = u_side;
    end
  end

  logic [WIDTH:0] fin;
  logic           fin_vld;
  csa_side_t      fin_side;

  assign fin_side = g_lvl[LAST].q_side;
  assign fin_vld  = g_lvl[LAST].q_vld;
  assign fin      = fin_side.cin ? g_lvl[LAST].q1 : g_lvl[LAST].q0;

  // ---- output slice: final carry-in select, overflow, result registers ----
  // Result bits load only with a real beat so bubbles never disturb held values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= fin_vld;
      if (fin_vld) begin
        out_sum  <= fin[WIDTH-1:0];
        out_cout <= fin[WIDTH];
        out_ovf  <= ovf_of(fin_side.a_msb, fin_side.b_msb, fin[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed-vector bench for csa_pipe_adder: a 32-bit instance with a hand-computed
// table and back-pressure traffic, plus 16-bit and 8-bit (two levels per slice) instances.
module tb_csa_pipe_adder;
  import csa_pkg::*;

  localparam int NST32 = csa_nstage(csa_clog2(32), 1);
  localparam int NST16 = csa_nstage(csa_clog2(16), 1);
  localparam int NST8  = csa_nstage(csa_clog2(8), 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid = 1'b0, in_ready, in_cin = 1'b0, in_sub = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_valid, out_ready = 1'b1, out_cout, out_ovf;
  logic [31:0] out_sum;

  // 16-bit instance
  logic        h_in_valid = 1'b0, h_in_ready, h_cin = 1'b0, h_sub = 1'b0;
  logic [15:0] h_a = '0, h_b = '0;
  logic        h_out_valid, h_out_ready = 1'b1, h_cout, h_ovf;
  logic [15:0] h_sum;

  // 8-bit instance, slice every two levels
  logic        e_in_valid = 1'b0, e_in_ready, e_cin = 1'b0, e_sub = 1'b0;
  logic [7:0]  e_a = '0, e_b = '0;
  logic        e_out_valid, e_out_ready = 1'b1, e_cout, e_ovf;
  logic [7:0]  e_sum;

  csa_pipe_adder #(.WIDTH(32), .PIPE_EVERY(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf));

  csa_pipe_adder #(.WIDTH(16), .PIPE_EVERY(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_a), .in_b(h_b), .in_cin(h_cin), .in_sub(h_sub),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_sum(h_sum),
    .out_cout(h_cout), .out_ovf(h_ovf));

  csa_pipe_adder #(.WIDTH(8), .PIPE_EVERY(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_a(e_a), .in_b(e_b), .in_cin(e_cin), .in_sub(e_sub),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_sum(e_sum),
    .out_cout(e_cout), .out_ovf(e_ovf));

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  vec_t       vecs[14];
  res_t       exp_q[$];
  res_t       cur_exp;
  res_t       got, want, held;
  logic [9:0] e_q[$];
  logic [9:0] e_got, e_want;
  bit         stalled_prev = 0;
  int         checks = 0;
  int         errors = 0;
  int         e_fires = 0;
  int         e_stalls = 0;
  int         n;
  bit         seen;

  // Arithmetic reference: {ovf, cout, sum} for a w-bit add/sub.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub, input int w);
    logic [63:0] mask, am, be;
    logic [64:0] full;
    logic [65:0] r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    be   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, be} + {64'd0, (sub | cin)};
    r          = '0;
    r[63:0]    = full[63:0] & mask;
    r[64]      = full[w];
    r[65]      = (am[w-1] == be[w-1]) && (full[w-1] != am[w-1]);
    return r;
  endfunction

  function automatic res_t model32(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
    logic [65:0] m;
    m = model({32'd0, a}, {32'd0, b}, cin, sub, 32);
    return {m[31:0], m[64], m[65]};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic sub, input logic [31:0] s, input logic c,
                              input logic o);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.exp = {s, c, o};
    return v;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input res_t e, input bit rnd_rdy);
    int tries;
    bit ok;
    tries = 0;
    ok = 0;
    while (!ok && tries < 100) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
      cur_exp = e;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      tries++;
      ok = in_ready;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
    end
  endtask

  task automatic idle(input bit rnd_rdy);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic h_run(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic [15:0] s,
                       input logic c, input logic o);
    int k;
    bit hit;
    @(posedge clk); #1;
    h_in_valid = 1'b1; h_a = a; h_b = b; h_cin = cin; h_sub = sub;
    k = 0;
    hit = 0;
    while (!hit && k < 20) begin
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      k++;
      hit = h_out_valid;
    end
    checks++;
    if (k != NST16) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, k, NST16);
    end
    checks++;
    if ({h_sum, h_cout, h_ovf} != {s, c, o}) begin
      errors++;
      $display("FAIL %s: got sum=%h cout=%0b ovf=%0b, required sum=%h cout=%0b ovf=%0b",
               name, h_sum, h_cout, h_ovf, s, c, o);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    vecs[1]  = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    vecs[2]  = mk(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    vecs[3]  = mk(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
    vecs[4]  = mk(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    vecs[5]  = mk(32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0);
    vecs[6]  = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    vecs[7]  = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    vecs[8]  = mk(32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    vecs[9]  = mk(32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0);
    vecs[10] = mk(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    vecs[11] = mk(32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    vecs[12] = mk(32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    vecs[13] = mk(32'h0000000A, 32'h00000003, 1'b0, 1'b1, 32'h00000007, 1'b1, 1'b0);

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          stalled_prev = 0;
        end else begin
          if (in_valid && in_ready) exp_q.push_back(cur_exp);
          if (stalled_prev) begin
            checks++;
            if (!out_valid || {out_sum, out_cout, out_ovf} != held) begin
              errors++;
              $display("FAIL stall_hold: got valid=%0b %h, required valid=1 %h",
                       out_valid, {out_sum, out_cout, out_ovf}, held);
            end
          end
          stalled_prev = out_valid && !out_ready;
          held = {out_sum, out_cout, out_ovf};
          if (out_valid && out_ready) begin
            checks++;
            got = {out_sum, out_cout, out_ovf};
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_result: got sum=%h, required no output", out_sum);
            end else begin
              want = exp_q.pop_front();
              if (got != want) begin
                errors++;
                $display("FAIL result32: got sum=%h cout=%0b ovf=%0b, required sum=%h cout=%0b ovf=%0b",
                         got.sum, got.cout, got.ovf, want.sum, want.cout, want.ovf);
              end
            end
          end
        end
      end
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (e_in_valid && e_in_ready) begin
            logic [65:0] m;
            m = model({56'd0, e_a}, {56'd0, e_b}, e_cin, e_sub, 8);
            e_q.push_back({m[65], m[64], m[7:0]});
          end
          if (e_out_valid && e_out_ready) begin
            checks++;
            e_fires++;
            e_got = {e_ovf, e_cout, e_sum};
            if (e_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_result8: got %h, required no output", e_got);
            end else begin
              e_want = e_q.pop_front();
              if (e_got != e_want) begin
                errors++;
                $display("FAIL result8: got {ovf,cout,sum}=%h, required %h", e_got, e_want);
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_sum, out_cout, out_ovf, in_ready} != {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state32: got valid=%0b sum=%h cout=%0b ovf=%0b ready=%0b, required 0/0/0/0/1",
               out_valid, out_sum, out_cout, out_ovf, in_ready);
    end
    checks++;
    if ({h_out_valid, h_sum, e_out_valid, e_sum} != '0) begin
      errors++;
      $display("FAIL reset_state_small: got h_valid=%0b h_sum=%h e_valid=%0b e_sum=%h, required 0",
               h_out_valid, h_sum, e_out_valid, e_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Latency on the 32-bit instance with an empty pipeline
    send(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, vecs[0].exp, 1'b0);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
      seen = out_valid;
    end
    checks++;
    if (n != NST32) begin
      errors++;
      $display("FAIL latency32: got %0d cycles, required %0d", n, NST32);
    end
    drain();

    // Table vectors back to back
    for (int i = 1; i < 14; i++) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp, 1'b0);
    drain();

    // Random traffic with random gaps and back-pressure
    for (int j = 0; j < 100; j++) begin
      logic [31:0] ra, rb;
      logic rc, rs;
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) idle(1'b1);
      send(ra, rb, rc, rs, model32(ra, rb, rc, rs), 1'b1);
    end
    drain();

    // Reset with three beats in flight
    for (int j = 0; j < 3; j++) send(32'h100 + j, 32'h1, 1'b0, 1'b0, model32(32'h100 + j, 32'h1, 1'b0, 1'b0), 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'd0) begin
      errors++;
      $display("FAIL reset_midstream: got valid=%0b sum=%h, required 0/0", out_valid, out_sum);
    end
    exp_q.delete();
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got valid=%0b, required 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL stale_after_reset: got %0d valid cycles, required 0", n);
    end
    send(vecs[4].a, vecs[4].b, vecs[4].cin, vecs[4].sub, vecs[4].exp, 1'b0);
    drain();

    // 16-bit instance
    h_run("add16", 16'h00CD, 16'h00FC, 1'b1, 1'b0, 16'h01CA, 1'b0, 1'b0);
    h_run("sub16", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // 8-bit instance: latency, then a continuous stream
    @(posedge clk); #1;
    e_in_valid = 1'b1; e_a = 8'h7F; e_b = 8'h01; e_cin = 1'b0; e_sub = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      e_in_valid = 1'b0;
      n++;
      seen = e_out_valid;
    end
    checks++;
    if (n != NST8) begin
      errors++;
      $display("FAIL latency8: got %0d cycles, required %0d", n, NST8);
    end
    repeat (3) @(posedge clk);
    for (int j = 0; j < 200; j++) begin
      @(posedge clk); #1;
      e_in_valid = 1'b1;
      e_a = 8'($urandom_range(0, 255)); e_b = 8'($urandom_range(0, 255));
      e_cin = 1'($urandom_range(0, 1)); e_sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!e_in_ready) e_stalls++;
    end
    @(posedge clk); #1;
    e_in_valid = 1'b0;
    repeat (NST8 + 3) @(posedge clk);
    #1;
    checks++;
    if (e_stalls != 0) begin
      errors++;
      $display("FAIL throughput8: got %0d stalled cycles, required 0", e_stalls);
    end
    checks++;
    if (e_fires != 201 || e_q.size() != 0) begin
      errors++;
      $display("FAIL count8: got %0d results with %0d pending, required 201 and 0", e_fires, e_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
